// File: rtl/readout_arbiter.sv
// Readout arbiter: merges a TLU word source and an FE data source into one sink.
// TLU has strict priority at IDLE and gets one word per grant; FE gets bursts of up
// to FE_BURST_LEN words that are never preempted. Sink back-pressure freezes the FSM.
module readout_arbiter #(
  parameter int unsigned FE_BURST_LEN = 16,
  parameter int unsigned CNT_WIDTH    = 32
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 ENABLE,
  input  logic                 TLU_FIFO_EMPTY,
  input  logic [31:0]          TLU_FIFO_DATA,
  output logic                 TLU_FIFO_READ,
  input  logic                 FE_FIFO_EMPTY,
  input  logic [31:0]          FE_FIFO_DATA,
  output logic                 FE_FIFO_READ,
  input  logic                 OUT_FIFO_FULL,
  output logic                 OUT_FIFO_WRITE,
  output logic [31:0]          OUT_FIFO_DATA,
  input  logic                 COUNT_CLEAR,
  output logic [1:0]           GRANT,
  output logic [CNT_WIDTH-1:0] WORD_COUNT
);

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StTlu  = 2'b01,
    StFe   = 2'b10
  } state_e;

  localparam logic [7:0] BurstLast = 8'(FE_BURST_LEN - 1);
  localparam logic [CNT_WIDTH-1:0] CntOne = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_e               state_q, state_d;
  logic [7:0]           burst_q, burst_d;
  logic                 tlu_read, fe_read;
  logic                 out_write_q;
  logic [31:0]          out_data_q;
  logic [CNT_WIDTH-1:0] count_q;

  // Pop strobes: only the granted source, only with sink room, never during reset.
  always_comb begin
    tlu_read = (state_q == StTlu) & ~TLU_FIFO_EMPTY & ~OUT_FIFO_FULL & ~RESET;
    fe_read  = (state_q == StFe)  & ~FE_FIFO_EMPTY  & ~OUT_FIFO_FULL & ~RESET;
  end

  // Next-state and burst counter; a full sink freezes the FSM in every state.
  always_comb begin
    state_d = state_q;
    burst_d = burst_q;
    if (fe_read) burst_d = burst_q + 8'd1;
    if (!OUT_FIFO_FULL) begin
      unique case (state_q)
        StIdle: begin
          if (ENABLE && !TLU_FIFO_EMPTY) begin
            state_d = StTlu;
          end else if (ENABLE && !FE_FIFO_EMPTY) begin
            state_d = StFe;
            burst_d = 8'd0;
          end
        end
        // Not full here, so the word was either popped or the source withdrew.
        StTlu: state_d = StIdle;
        StFe: begin
          if ((fe_read && burst_q == BurstLast) || FE_FIFO_EMPTY || !ENABLE) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State register and burst counter.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= StIdle;
      burst_q <= 8'd0;
    end else begin
      state_q <= state_d;
      burst_q <= burst_d;
    end
  end

  // Sink write port: registered copy of the word popped on the previous cycle.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      out_write_q <= 1'b0;
      out_data_q  <= 32'd0;
    end else begin
      out_write_q <= tlu_read | fe_read;
      if (tlu_read) begin
        out_data_q <= TLU_FIFO_DATA;
      end else if (fe_read) begin
        out_data_q <= FE_FIFO_DATA;
      end
    end
  end

  // Saturating write counter; clear beats increment.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      count_q <= '0;
    end else if (COUNT_CLEAR) begin
      count_q <= '0;
    end else if (out_write_q && count_q != '1) begin
      count_q <= count_q + CntOne;
    end
  end

  assign TLU_FIFO_READ  = tlu_read;
  assign FE_FIFO_READ   = fe_read;
  assign OUT_FIFO_WRITE = out_write_q;
  assign OUT_FIFO_DATA  = out_data_q;
  assign GRANT          = state_q;
  assign WORD_COUNT     = count_q;

endmodule

// File: tb/tb_readout_arbiter.sv
// Randomized bench for readout_arbiter with a cycle-level behavioural model.
// Sources are FWFT queues owned by the bench; a second CNT_WIDTH=4 instance shares
// all inputs to exercise counter saturation.
module tb_readout_arbiter;

  localparam int BurstLen = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        tlu_empty = 1'b1;
  logic [31:0] tlu_data = 32'd0;
  logic        fe_empty = 1'b1;
  logic [31:0] fe_data = 32'd0;
  logic        out_full = 1'b0;
  logic        count_clear = 1'b0;
  logic        tlu_read, fe_read, out_write;
  logic [31:0] out_data;
  logic [1:0]  grant;
  logic [31:0] word_count;
  logic        s_tlu_read, s_fe_read, s_out_write;
  logic [31:0] s_out_data;
  logic [1:0]  s_grant;
  logic [3:0]  s_word_count;

  always #5 clk = ~clk;

  readout_arbiter #(.FE_BURST_LEN(BurstLen), .CNT_WIDTH(32)) u_dut (
    .CLK(clk), .RESET(rst), .ENABLE(enable),
    .TLU_FIFO_EMPTY(tlu_empty), .TLU_FIFO_DATA(tlu_data), .TLU_FIFO_READ(tlu_read),
    .FE_FIFO_EMPTY(fe_empty), .FE_FIFO_DATA(fe_data), .FE_FIFO_READ(fe_read),
    .OUT_FIFO_FULL(out_full), .OUT_FIFO_WRITE(out_write), .OUT_FIFO_DATA(out_data),
    .COUNT_CLEAR(count_clear), .GRANT(grant), .WORD_COUNT(word_count)
  );

  readout_arbiter #(.FE_BURST_LEN(BurstLen), .CNT_WIDTH(4)) u_dut_small (
    .CLK(clk), .RESET(rst), .ENABLE(enable),
    .TLU_FIFO_EMPTY(tlu_empty), .TLU_FIFO_DATA(tlu_data), .TLU_FIFO_READ(s_tlu_read),
    .FE_FIFO_EMPTY(fe_empty), .FE_FIFO_DATA(fe_data), .FE_FIFO_READ(s_fe_read),
    .OUT_FIFO_FULL(out_full), .OUT_FIFO_WRITE(s_out_write), .OUT_FIFO_DATA(s_out_data),
    .COUNT_CLEAR(count_clear), .GRANT(s_grant), .WORD_COUNT(s_word_count)
  );

  logic [31:0] tlu_q[$];
  logic [31:0] fe_q[$];
  int unsigned tlu_seq = 0;
  int unsigned fe_seq = 0;

  // Model: owner 0 = nobody, 1 = TLU, 2 = FE; words taken in the current FE burst.
  int          m_owner = 0;
  int          m_taken = 0;
  bit          m_wr = 1'b0;
  logic [31:0] m_data = 32'd0;
  longint      m_cnt = 0;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic push_tlu();
    tlu_q.push_back({8'h71, 24'(tlu_seq)});
    tlu_seq++;
  endtask

  task automatic push_fe(input int n);
    for (int i = 0; i < n; i++) begin
      fe_q.push_back({8'hFE, 24'(fe_seq)});
      fe_seq++;
    end
  endtask

  // Assert reset mid-cycle; everything must read as reset values immediately.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_tlu_read", tlu_read, 0);
    check("rst_fe_read", fe_read, 0);
    check("rst_grant", grant, 0);
    check("rst_write", out_write, 0);
    check("rst_data", out_data, 0);
    check("rst_count", word_count, 0);
    check("rst_count_small", s_word_count, 0);
    m_owner = 0;
    m_taken = 0;
    m_wr    = 1'b0;
    m_data  = 32'd0;
    m_cnt   = 0;
  endtask

  // One clock cycle: drive, compare against the model, then advance model and sources.
  task automatic step(input bit en, input bit full, input bit clr);
    bit   e_tlu, e_fe, took, done;
    logic o_tlu, o_fe;
    @(negedge clk);
    rst         = 1'b0;
    enable      = en;
    out_full    = full;
    count_clear = clr;
    tlu_empty   = (tlu_q.size() == 0);
    tlu_data    = tlu_empty ? 32'd0 : tlu_q[0];
    fe_empty    = (fe_q.size() == 0);
    fe_data     = fe_empty ? 32'd0 : fe_q[0];
    #1;
    e_tlu = (m_owner == 1) && (tlu_q.size() > 0) && !full;
    e_fe  = (m_owner == 2) && (fe_q.size() > 0) && !full;
    check("tlu_read", tlu_read, e_tlu);
    check("fe_read", fe_read, e_fe);
    check("grant", grant, m_owner);
    check("out_write", out_write, m_wr);
    check("out_data", out_data, m_data);
    check("word_count", word_count, m_cnt);
    check("word_count_sat4", s_word_count, (m_cnt > 15) ? 15 : m_cnt);
    o_tlu = tlu_read;
    o_fe  = fe_read;
    @(posedge clk);
    // Sink side: the popped word lands one cycle later, counter follows the write.
    if (clr) m_cnt = 0;
    else if (m_wr) m_cnt++;
    took = e_tlu || e_fe;
    if (e_tlu) m_data = tlu_q[0];
    else if (e_fe) m_data = fe_q[0];
    m_wr = took;
    // Arbitration rules; a full sink stalls everything.
    if (!full) begin
      if (m_owner == 0) begin
        if (en && tlu_q.size() > 0) m_owner = 1;
        else if (en && fe_q.size() > 0) begin
          m_owner = 2;
          m_taken = 0;
        end
      end else if (m_owner == 1) begin
        m_owner = 0;
      end else begin
        if (e_fe) m_taken++;
        done = (m_taken == BurstLen) || (fe_q.size() == 0) || !en;
        if (done) m_owner = 0;
      end
    end
    if (o_tlu && tlu_q.size() > 0) void'(tlu_q.pop_front());
    if (o_fe && fe_q.size() > 0) void'(fe_q.pop_front());
  endtask

  initial begin
    do_reset();

    // Single TLU word appearing after an idle stretch.
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0);
    tlu_q.push_back(32'h8000_1234);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    check("single_tlu_data", out_data, 32'h8000_1234);
    step(1'b1, 1'b0, 1'b0);
    check("single_tlu_count", word_count, 1);

    // TLU and a 40-word FE stream together, TLU injected mid-burst.
    push_tlu();
    push_fe(40);
    for (int i = 0; i < 80; i++) begin
      if (i == 20) push_tlu();
      step(1'b1, 1'b0, 1'b0);
    end
    check("sat_hold", s_word_count, 15);

    // Sink full for five cycles in the middle of a burst.
    push_fe(30);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 40; i++) step(1'b1, 1'b0, 1'b0);

    // Short FE source ends its own grant.
    push_fe(3);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0);
    check("short_burst_idle", grant, 0);

    // Reset when the fourth burst word would be popped.
    push_fe(20);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0);
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0);
    fe_q.delete();

    // Clear coincident with a write.
    push_tlu();
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    check("clr_wins", word_count, 0);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(99) < 8) push_tlu();
      if ($urandom_range(99) < 20) push_fe(int'($urandom_range(8, 1)));
      if ($urandom_range(999) < 3) begin
        do_reset();
      end else begin
        step($urandom_range(99) < 90, $urandom_range(99) < 15, $urandom_range(99) < 2);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/readout_arbiter.md
READOUT_ARBITER -- requirements
Module: readout_arbiter

Interface
REQ-001 Parameter: FE_BURST_LEN, 16, max FE words per grant (range 1..255).
REQ-002 Parameter: CNT_WIDTH, 32, width of WORD_COUNT.
REQ-003 Port: CLK  in  1  single clock for the whole block.
REQ-004 Port: RESET  in  1  reset; one clock, reset asynchronous and active-high.
REQ-005 Port: ENABLE  in  1  arbitration enable; low = no new grants.
REQ-006 Port: TLU_FIFO_EMPTY  in  1  TLU source has no word (first-word-fall-through).
REQ-007 Port: TLU_FIFO_DATA  in  32  TLU word, valid while TLU_FIFO_EMPTY low.
REQ-008 Port: TLU_FIFO_READ  out  1  pop TLU word, one cycle per word.
REQ-009 Port: FE_FIFO_EMPTY  in  1  FE data source empty (first-word-fall-through).
REQ-010 Port: FE_FIFO_DATA  in  32  FE word, valid while FE_FIFO_EMPTY low.
REQ-011 Port: FE_FIFO_READ  out  1  pop FE word, one cycle per word.
REQ-012 Port: OUT_FIFO_FULL  in  1  sink almost-full; sink guarantees room for one more word after assertion.
REQ-013 Port: OUT_FIFO_WRITE  out  1  write strobe to sink.
REQ-014 Port: OUT_FIFO_DATA  out  32  word to sink.
REQ-015 Port: COUNT_CLEAR  in  1  synchronous clear of WORD_COUNT.
REQ-016 Port: GRANT  out  2  current state: 00 IDLE, 01 TLU_GRANT, 10 FE_GRANT.
REQ-017 Port: WORD_COUNT  out  CNT_WIDTH  words written to sink, saturating.

Function
REQ-018 FSM states IDLE, TLU_GRANT, FE_GRANT; state register clocked, GRANT reflects registered state.
REQ-019 IDLE: ENABLE & !TLU_FIFO_EMPTY -> TLU_GRANT; else ENABLE & !FE_FIFO_EMPTY -> FE_GRANT; else stay.
REQ-020 Both sources non-empty in IDLE: TLU wins (strict priority).
REQ-021 TLU_FIFO_READ = (state==TLU_GRANT) & !TLU_FIFO_EMPTY & !OUT_FIFO_FULL, combinational.
REQ-022 TLU_GRANT -> IDLE on the cycle TLU_FIFO_READ is high; exactly one TLU word per grant.
REQ-023 TLU_GRANT with TLU_FIFO_EMPTY high (source withdrew): -> IDLE, no read.
REQ-024 FE_FIFO_READ = (state==FE_GRANT) & !FE_FIFO_EMPTY & !OUT_FIFO_FULL, combinational; back-to-back reads allowed.
REQ-025 Burst counter (8 bit) cleared on entry to FE_GRANT, +1 per FE_FIFO_READ.
REQ-026 FE_GRANT -> IDLE when: FE_FIFO_READ high and counter==FE_BURST_LEN-1; or FE_FIFO_EMPTY high; or ENABLE low (after any read in that cycle).
REQ-027 FE burst is never preempted by TLU; TLU served at next IDLE, so max TLU wait = FE_BURST_LEN+2 cycles with sink not full.
REQ-028 OUT_FIFO_FULL high: no READ issued, state held (stall), counters unchanged.
REQ-029 OUT_FIFO_WRITE registered: high exactly one cycle after each TLU/FE READ; OUT_FIFO_DATA = popped word, registered in same edge.
REQ-030 OUT_FIFO_DATA holds last value when OUT_FIFO_WRITE low.
REQ-031 TLU_FIFO_READ and FE_FIFO_READ never high in same cycle.
REQ-032 WORD_COUNT +1 per OUT_FIFO_WRITE; saturates at all-ones; COUNT_CLEAR wins over increment in same cycle.
REQ-033 Latency: source EMPTY falls at cycle N in IDLE -> READ at N+1 -> OUT_FIFO_WRITE at N+2.

Reset
REQ-034 RESET high asynchronously forces: state IDLE, GRANT 00, burst counter 0, OUT_FIFO_WRITE 0, OUT_FIFO_DATA 0, WORD_COUNT 0; READ outputs 0 while RESET high.
REQ-035 Reset mid-burst: word popped in the cycle reset asserts is discarded; no write after release until new grant.
REQ-036 After RESET release, first grant decided in first clock edge per REQ-019.

Verification
REQ-037 Only TLU word 0x8000_1234 at cycle 10 -> TLU_FIFO_READ at 11, OUT_FIFO_WRITE with 0x8000_1234 at 12, WORD_COUNT=1.
REQ-038 TLU and FE (40 words) non-empty together -> TLU word first, then FE bursts of 16, TLU words injected mid-burst appear only between bursts.
REQ-039 OUT_FIFO_FULL high for 5 cycles mid-FE-burst -> no READ for 5 cycles, burst resumes, no word lost/duplicated, order preserved.
REQ-040 FE source with 3 words, FE_BURST_LEN=16 -> 3 reads, FE_FIFO_EMPTY ends grant, GRANT returns 00.
REQ-041 RESET pulse at 4th word of FE burst -> all outputs at reset values, WORD_COUNT=0, no OUT_FIFO_WRITE cycle after reset.
REQ-042 WORD_COUNT preset near all-ones (CNT_WIDTH=4 build) + 20 writes -> holds 0xF; COUNT_CLEAR with concurrent write -> 0.
